// File: rtl/voter_pkg.sv
// Shared types and helpers for the TMR voter with replica fault management.
package voter_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAULTY  = 2'b10
  } rep_state_e;

  localparam int NUM_REP = 3;

  // Lowest set index of the mask; replica 0 when no bit is set.
  function automatic logic [1:0] first_healthy(input logic [NUM_REP-1:0] mask);
    first_healthy = 2'd0;
    for (int i = NUM_REP - 1; i >= 0; i--) begin
      if (mask[i]) first_healthy = 2'(i);
    end
  endfunction

endpackage

// File: rtl/maj3_mask.sv
// One W-bit group voter: full 2-of-3 majority when all replicas are healthy,
// otherwise votes among the non-faulty replicas only.
module maj3_mask
  import voter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]       in_1,
  input  logic [W-1:0]       in_2,
  input  logic [W-1:0]       in_3,
  input  logic [NUM_REP-1:0] healthy,
  output logic [W-1:0]       voted,
  output logic [NUM_REP-1:0] disagree,
  output logic               corrected,
  output logic               uncorrectable
);

  logic eq12, eq13, eq23;
  logic [1:0] sel;

  assign eq12 = (in_1 == in_2);
  assign eq13 = (in_1 == in_3);
  assign eq23 = (in_2 == in_3);
  assign sel  = first_healthy(healthy);

  always_comb begin
    voted         = in_1;
    disagree      = '0;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    case (healthy)
      3'b111: begin
        if (eq12 && eq13) begin
          voted = in_1;
        end else if (eq12) begin
          disagree[2] = 1'b1;
          corrected   = 1'b1;
        end else if (eq13) begin
          disagree[1] = 1'b1;
          corrected   = 1'b1;
        end else if (eq23) begin
          voted       = in_2;
          disagree[0] = 1'b1;
          corrected   = 1'b1;
        end else begin
          uncorrectable = 1'b1;
        end
      end
      // Degraded: only the two surviving replicas are compared.
      3'b110: begin
        voted         = in_2;
        uncorrectable = !eq23;
      end
      3'b101: begin
        voted         = in_1;
        uncorrectable = !eq13;
      end
      3'b011: begin
        voted         = in_1;
        uncorrectable = !eq12;
      end
      default: begin
        case (sel)
          2'd1:    voted = in_2;
          2'd2:    voted = in_3;
          default: voted = in_1;
        endcase
        uncorrectable = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tmr_voter_fault_mgr.sv
// N_GRP-group TMR voter with per-replica suspect/faulty tracking, saturating
// mismatch counters and a valid/ready fault-event report channel.
module tmr_voter_fault_mgr
  import voter_pkg::*;
#(
  parameter int          N_GRP    = 4,
  parameter int          W        = 8,
  parameter int          CNT_W    = 8,
  parameter int unsigned PERM_THR = 3,
  parameter bit          REG_OUT  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic [N_GRP*W-1:0]       in_1_i,
  input  logic [N_GRP*W-1:0]       in_2_i,
  input  logic [N_GRP*W-1:0]       in_3_i,
  input  logic                     clear_i,
  output logic [N_GRP*W-1:0]       voted_o,
  output logic                     voted_valid_o,
  output logic [N_GRP-1:0]         err_corrected_o,
  output logic [N_GRP-1:0]         err_uncorrectable_o,
  output logic [NUM_REP*2-1:0]     rep_state_o,
  output logic [NUM_REP*CNT_W-1:0] err_cnt_o,
  output logic                     report_valid_o,
  input  logic                     report_ready_i,
  output logic [1:0]               report_rep_o,
  output logic                     report_ovf_o
);

  localparam int CONS_W = 8;

  logic [NUM_REP-1:0]       healthy;
  logic [NUM_REP-1:0]       enter_faulty;
  logic [N_GRP*W-1:0]       voted_c;
  logic [N_GRP*NUM_REP-1:0] disagree_flat;
  logic [N_GRP-1:0]         corr_c, unc_c, corr_v, unc_v;
  logic [NUM_REP-1:0]       disagree_or, mismatch;
  logic                     update_en;

  for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
    maj3_mask #(.W(W)) u_maj (
      .in_1          (in_1_i[gi*W +: W]),
      .in_2          (in_2_i[gi*W +: W]),
      .in_3          (in_3_i[gi*W +: W]),
      .healthy       (healthy),
      .voted         (voted_c[gi*W +: W]),
      .disagree      (disagree_flat[gi*NUM_REP +: NUM_REP]),
      .corrected     (corr_c[gi]),
      .uncorrectable (unc_c[gi])
    );
  end

  always_comb begin
    disagree_or = '0;
    for (int g = 0; g < N_GRP; g++) disagree_or |= disagree_flat[g*NUM_REP +: NUM_REP];
  end

  // Any no-majority group freezes all replica bookkeeping for the cycle.
  assign update_en = valid_i && !(|unc_c);
  assign mismatch  = disagree_or & {NUM_REP{update_en}};
  assign corr_v    = corr_c & {N_GRP{valid_i}};
  assign unc_v     = unc_c & {N_GRP{valid_i}};

  for (genvar gi = 0; gi < NUM_REP; gi++) begin : g_rep
    rep_state_e        state_reg, state_next;
    logic [CONS_W-1:0] cons_reg, cons_next, cons_inc;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              healthy_l, enter_l;

    assign cons_inc = cons_reg + CONS_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg <= HEALTHY;
        cons_reg  <= '0;
        cnt_reg   <= '0;
      end else if (clear_i) begin
        state_reg <= HEALTHY;
        cons_reg  <= '0;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        cons_reg  <= cons_next;
        cnt_reg   <= cnt_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      cons_next  = cons_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
        HEALTHY: begin
          if (mismatch[gi]) begin
            cons_next  = CONS_W'(1);
            state_next = (PERM_THR <= 1) ? FAULTY : SUSPECT;
          end
        end
        SUSPECT: begin
          if (mismatch[gi]) begin
            cons_next = cons_inc;
            if (cons_inc >= CONS_W'(PERM_THR)) state_next = FAULTY;
          end else if (update_en) begin
            cons_next  = '0;
            state_next = HEALTHY;
          end
        end
        default: state_next = FAULTY;
      endcase
      if (mismatch[gi] && (state_reg != FAULTY) && (cnt_reg != {CNT_W{1'b1}}))
        cnt_next = cnt_reg + CNT_W'(1);
    end

    always_comb begin
      healthy_l = (state_reg != FAULTY);
      enter_l   = healthy_l && (state_next == FAULTY);
    end

    assign healthy[gi]                    = healthy_l;
    assign enter_faulty[gi]               = enter_l;
    assign rep_state_o[gi*2 +: 2]         = state_reg;
    assign err_cnt_o[gi*CNT_W +: CNT_W]   = cnt_reg;
  end

  logic       report_valid_reg, report_ovf_reg, accept;
  logic [1:0] report_rep_reg;

  assign accept = report_valid_reg && report_ready_i;

  // Only one event is buffered; anything arriving while it is outstanding is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      report_valid_reg <= 1'b0;
      report_rep_reg   <= 2'd0;
      report_ovf_reg   <= 1'b0;
    end else if (clear_i) begin
      report_valid_reg <= 1'b0;
      report_rep_reg   <= 2'd0;
      report_ovf_reg   <= 1'b0;
    end else if (|enter_faulty) begin
      if (report_valid_reg) begin
        report_ovf_reg   <= 1'b1;
        report_valid_reg <= !accept;
      end else begin
        report_valid_reg <= 1'b1;
        report_rep_reg   <= first_healthy(enter_faulty);
        if ($countones(enter_faulty) > 1) report_ovf_reg <= 1'b1;
      end
    end else if (accept) begin
      report_valid_reg <= 1'b0;
    end
  end

  assign report_valid_o = report_valid_reg;
  assign report_rep_o   = report_rep_reg;
  assign report_ovf_o   = report_ovf_reg;

  if (REG_OUT) begin : g_reg_out
    logic [N_GRP*W-1:0] voted_reg;
    logic               voted_valid_reg;
    logic [N_GRP-1:0]   corr_reg, unc_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        voted_reg       <= '0;
        voted_valid_reg <= 1'b0;
        corr_reg        <= '0;
        unc_reg         <= '0;
      end else begin
        voted_reg       <= voted_c;
        voted_valid_reg <= valid_i;
        corr_reg        <= corr_v;
        unc_reg         <= unc_v;
      end
    end

    assign voted_o             = voted_reg;
    assign voted_valid_o       = voted_valid_reg;
    assign err_corrected_o     = corr_reg;
    assign err_uncorrectable_o = unc_reg;
  end else begin : g_comb_out
    assign voted_o             = voted_c;
    assign voted_valid_o       = valid_i;
    assign err_corrected_o     = corr_v;
    assign err_uncorrectable_o = unc_v;
  end

endmodule
